ram_stream_loader: RTL
======================

Name: ram_stream_loader

Overview:
- Avalon-ST sink to single-port on-chip RAM write master.
- Sits directly upstream of the 1024x32 on-chip RAM and drives its address, byteenable, chipselect, write, writedata and clken inputs.
- Once armed by `start`, captures one packet from a streaming source into RAM at a programmable base address.
- Reports word count, completion and truncation/error status to the HPS-side control logic.

Parameters:
- ADDR_W, 10, RAM word-address width; addresses wrap modulo 2**ADDR_W.
- DATA_W, 32, stream and RAM data width; fixed at 4 bytes for byteenable rules.
- CNT_W, 11, width of word counter and max_words (holds 0..2**ADDR_W).

Ports:
- clk  in  1  system clock; all logic on rising edge.
- reset_n  in  1  asynchronous active-low reset.
- start  in  1  single-cycle arm request; honoured only in IDLE.
- base_addr  in  ADDR_W  first RAM word address; sampled on accepted start.
- max_words  in  CNT_W  packet word limit, sampled on start; 0 means 2**ADDR_W.
- busy  out  1  high in any state other than IDLE.
- done  out  1  one-cycle pulse when the packet is finished.
- word_count  out  CNT_W  words written for the current/last packet; held until next start.
- overflow  out  1  sticky: packet exceeded max_words; cleared on start.
- err_sop  out  1  sticky: sop seen mid-packet; cleared on start.
- snk_data  in  DATA_W  stream data.
- snk_valid  in  1  stream valid.
- snk_ready  out  1  stream ready.
- snk_sop  in  1  start of packet.
- snk_eop  in  1  end of packet.
- snk_empty  in  2  unused bytes on the eop word.
- ram_address  out  ADDR_W  RAM word address.
- ram_byteenable  out  4  RAM byte enables.
- ram_chipselect  out  1  RAM chipselect.
- ram_write  out  1  RAM write strobe.
- ram_writedata  out  DATA_W  RAM write data.
- ram_clken  out  1  RAM clock enable; constant 1 after reset.

Behaviour:
- Reset (async, reset_n=0): state=IDLE.
  - All outputs 0 except ram_clken=0.
  - ram_clken rises to 1 on the first clock after reset_n deasserts.
- Handshake: a word is accepted when snk_valid & snk_ready on a clock edge. snk_ready is a registered function of state only, not of snk_valid.
- States:
  - IDLE: snk_ready=0. On start, latch base/limit, clear word_count/overflow/err_sop, go to WAIT_SOP.
  - WAIT_SOP: snk_ready=1.
    - Accepted words without sop are discarded.
    - An accepted word with sop is written as word 0. If it also has eop, go to FINISH; otherwise go to STREAM.
  - STREAM: snk_ready=1. Each accepted word is written at base+word_count.
    - eop: go to FINISH.
    - sop: set err_sop, reset word_count to 0, write this word at base (restart packet).
    - If word_count reaches the limit after a write and the word was not eop: set overflow, go to DISCARD.
  - DISCARD: snk_ready=1. Drop accepted words with no RAM write; on eop go to FINISH.
  - FINISH: snk_ready=0, done=1 for exactly one cycle, then IDLE.
- Write timing:
  - RAM write is registered: ram_write/ram_chipselect assert the cycle after acceptance, for one cycle per word.
  - Back-to-back accepts give back-to-back writes.
  - The last write completes in the same cycle done pulses.
- Address: ram_address = (base_addr + word_count) mod 2**ADDR_W; wrap from 1023 to 0 is legal and silent.
- Byteenable:
  - 4'b1111 for non-eop words.
  - eop word: 4'b1111 >> snk_empty (empty=1 gives 0111, empty=3 gives 0001).
  - snk_empty is ignored on non-eop words.
- Simultaneous events:
  - sop and eop on the same word is a 1-word packet.
  - A limit hit on the eop word ends normally with no overflow.
  - start while busy is ignored.
- word_count increments per RAM write, saturating at the limit; DISCARD does not count.
- reset_n asserted mid-packet aborts immediately; no partial RAM write is issued after reset asserts.

Decomposition:
- Shared package ram_loader_pkg holds:
  - state enum {IDLE, WAIT_SOP, STREAM, DISCARD, FINISH};
  - ADDR_W/DATA_W/CNT_W defaults;
  - the empty-to-byteenable function.
- Single module, no sub-module; the write-issue register stage is inline.

Test Plan:
- base=0x010, max=4; 4-word packet (sop on word0, eop on word3, empty=0) -> writes at 0x010..0x013, be=1111, word_count=4, done pulse, overflow=0.
- base=0x3FE, max=0; 4-word packet -> addresses 0x3FE, 0x3FF, 0x000, 0x001; word_count=4.
- max=2; 5-word packet -> writes only 2 words, overflow=1, ready held until eop accepted, done after eop, word_count=2.
- 2 non-sop words before a 1-word sop+eop packet with empty=2 -> pre-sop words dropped; single write, be=0011, word_count=1.
- sop reasserted on 3rd word of a packet -> err_sop=1; that word is written at base; final word_count counts from the restart.
- reset_n pulled low mid-STREAM with valid held -> ram_write=0, busy=0, snk_ready=0 immediately; start after release works normally.

Source files
------------

// File: rtl/ram_loader_pkg.sv
// Shared types and helpers for the Avalon-ST to on-chip RAM packet loader.
// Holds the FSM state encoding, default widths and the eop byteenable mapping.
package ram_loader_pkg;

    localparam int unsigned ADDR_W_DEF = 10;
    localparam int unsigned DATA_W_DEF = 32;
    localparam int unsigned CNT_W_DEF  = 11;
    localparam int unsigned BE_W       = 4;

    typedef enum logic [2:0] {
        IDLE,
        WAIT_SOP,
        STREAM,
        DISCARD,
        FINISH
    } state_t;

    // Full word unless this is the eop word, where trailing empty bytes are masked off.
    function automatic logic [BE_W-1:0] empty_to_be(input logic eop, input logic [1:0] empty);
        logic [BE_W-1:0] full;
        full = {BE_W{1'b1}};
        if (eop) begin
            return full >> empty;
        end
        return full;
    endfunction

endpackage

// File: rtl/ram_stream_loader.sv
// Captures one Avalon-ST packet into a single-port on-chip RAM at a programmable base.
// Reports word count, done, overflow and mid-packet sop to the control side.
module ram_stream_loader
    import ram_loader_pkg::*;
#(
    parameter int unsigned ADDR_W = ADDR_W_DEF,
    parameter int unsigned DATA_W = DATA_W_DEF,
    parameter int unsigned CNT_W  = CNT_W_DEF
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [CNT_W-1:0]  max_words,
    output logic              busy,
    output logic              done,
    output logic [CNT_W-1:0]  word_count,
    output logic              overflow,
    output logic              err_sop,
    input  logic [DATA_W-1:0] snk_data,
    input  logic              snk_valid,
    output logic              snk_ready,
    input  logic              snk_sop,
    input  logic              snk_eop,
    input  logic [1:0]        snk_empty,
    output logic [ADDR_W-1:0] ram_address,
    output logic [BE_W-1:0]   ram_byteenable,
    output logic              ram_chipselect,
    output logic              ram_write,
    output logic [DATA_W-1:0] ram_writedata,
    output logic              ram_clken
);

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   base_q, base_d;
    logic [CNT_W-1:0]    limit_q, limit_d;
    logic [CNT_W-1:0]    cnt_d, cnt_wr;
    logic                ovf_d, esop_d;
    logic                wr_d, ready_d, busy_d, done_d;
    logic [ADDR_W-1:0]   addr_d;
    logic [BE_W-1:0]     be_d;
    logic [DATA_W-1:0]   data_d;
    logic                accept, do_write, restart;

    assign accept = snk_valid & snk_ready;

    // State, packet context and the write-issue stage all register here.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q        <= IDLE;
            base_q         <= '0;
            limit_q        <= '0;
            word_count     <= '0;
            overflow       <= 1'b0;
            err_sop        <= 1'b0;
            busy           <= 1'b0;
            done           <= 1'b0;
            snk_ready      <= 1'b0;
            ram_address    <= '0;
            ram_byteenable <= '0;
            ram_chipselect <= 1'b0;
            ram_write      <= 1'b0;
            ram_writedata  <= '0;
            ram_clken      <= 1'b0;
        end else begin
            state_q        <= state_d;
            base_q         <= base_d;
            limit_q        <= limit_d;
            word_count     <= cnt_d;
            overflow       <= ovf_d;
            err_sop        <= esop_d;
            busy           <= busy_d;
            done           <= done_d;
            snk_ready      <= ready_d;
            ram_address    <= addr_d;
            ram_byteenable <= be_d;
            ram_chipselect <= wr_d;
            ram_write      <= wr_d;
            ram_writedata  <= data_d;
            ram_clken      <= 1'b1;
        end
    end

    // Next-state, packet bookkeeping and next write beat.
    always_comb begin
        state_d  = state_q;
        base_d   = base_q;
        limit_d  = limit_q;
        cnt_d    = word_count;
        cnt_wr   = word_count;
        ovf_d    = overflow;
        esop_d   = err_sop;
        wr_d     = 1'b0;
        addr_d   = ram_address;
        be_d     = ram_byteenable;
        data_d   = ram_writedata;
        do_write = 1'b0;
        restart  = 1'b0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    base_d  = base_addr;
                    limit_d = (max_words == '0) ? CNT_W'(2 ** ADDR_W) : max_words;
                    cnt_d   = '0;
                    ovf_d   = 1'b0;
                    esop_d  = 1'b0;
                    state_d = WAIT_SOP;
                end
            end
            WAIT_SOP: begin
                if (accept && snk_sop) begin
                    do_write = 1'b1;
                    restart  = 1'b1;
                end
            end
            STREAM: begin
                if (accept) begin
                    do_write = 1'b1;
                    if (snk_sop) begin
                        esop_d  = 1'b1;
                        restart = 1'b1;
                    end
                end
            end
            DISCARD: begin
                if (accept && snk_eop) begin
                    state_d = FINISH;
                end
            end
            FINISH:  state_d = IDLE;
            default: state_d = IDLE;
        endcase

        // A restart (first sop or a repeated sop) always lands back at the base address.
        if (do_write) begin
            cnt_wr = restart ? '0 : word_count;
            cnt_d  = cnt_wr + CNT_W'(1);
            wr_d   = 1'b1;
            addr_d = base_q + ADDR_W'(cnt_wr);
            be_d   = empty_to_be(snk_eop, snk_empty);
            data_d = snk_data;
            if (snk_eop) begin
                state_d = FINISH;
            end else if (cnt_d >= limit_q) begin
                ovf_d   = 1'b1;
                state_d = DISCARD;
            end else begin
                state_d = STREAM;
            end
        end

        ready_d = (state_d == WAIT_SOP) || (state_d == STREAM) || (state_d == DISCARD);
        busy_d  = (state_d != IDLE);
        done_d  = (state_d == FINISH);
    end

endmodule
